// File: rtl/spu_pkg.sv
// Shared definitions for the SPU front end.
// Contents:
//   NOP_INSTR  - word substituted for the skipped half of an odd-word branch target
//   if_pair_t  - one fetched instruction pair plus its even-word byte PC
//   fetch_state_t - fetch state machine encoding (RUN, STOPPED)
//   is_stop()  - true for a stop instruction (opcode bits [31:21] all zero)
package spu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h4020_0000;

    typedef struct packed {
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic [31:0] pc;
    } if_pair_t;

    typedef enum logic {
        RUN,
        STOPPED
    } fetch_state_t;

    function automatic logic is_stop(input logic [31:0] instr);
        return (instr[31:21] == 11'd0);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of instruction pairs used as the fetch prefetch buffer.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   push, push_data - write one pair (ignored when full)
//   pop        - remove the head pair (ignored when empty)
//   clear      - empty the FIFO; wins over push and pop in the same cycle
//   count      - number of stored pairs (0..DEPTH)
//   empty      - no pair stored
//   head       - oldest stored pair
module fetch_buf
    import spu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  if_pair_t                 push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output if_pair_t                 head
);

    localparam int PW = $clog2(DEPTH);

    if_pair_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Storage array is not reset; contents are only observable through head
    // when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Dual-issue instruction fetch stage.
// Reads aligned instruction pairs from the local-store instruction port,
// buffers them in fetch_buf and hands them to decode under IF_valid/dec_ready.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   imem_rd_en, imem_addr      - read strobe and doubleword address
//   imem_rdata                 - read data, one cycle after the strobe; [63:32] = lower word
//   instr_1/instr_2            - head pair (lower, higher address word)
//   PC_instr_1/PC_instr_2      - byte PCs of the head pair
//   IF_valid, dec_ready        - decode handshake
//   flush, branch_target       - redirect pulse and its byte target
module instr_fetch
    import spu_pkg::*;
#(
    parameter int          LS_ADDR_W = 18,
    parameter int          BUF_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_rd_en,
    output logic [LS_ADDR_W-4:0]   imem_addr,
    input  logic [63:0]            imem_rdata,
    output logic [31:0]            instr_1,
    output logic [31:0]            instr_2,
    output logic [31:0]            PC_instr_1,
    output logic [31:0]            PC_instr_2,
    output logic                   IF_valid,
    input  logic                   dec_ready,
    input  logic                   flush,
    input  logic [31:0]            branch_target
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t            state;
    fetch_state_t            next_state;
    logic [LS_ADDR_W-1:0]    fetch_pc;
    logic [LS_ADDR_W-1:0]    inflight_pc;
    logic                    inflight;
    logic                    skip_first;
    logic [CW-1:0]           count;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    if_pair_t                push_pair;
    if_pair_t                head;
    logic                    unused_target_bits;

    // Only the local-store-sized part of the target matters; the pair is
    // always fetched from the enclosing doubleword.
    assign unused_target_bits = ^{branch_target[31:LS_ADDR_W], branch_target[1:0]};

    // Credits count both stored pairs and the read still in flight, so a
    // returning read always has a free slot. A same-cycle pop is not counted.
    assign credit_ok = (({1'b0, count} + (CW + 1)'(inflight)) < (CW + 1)'(BUF_DEPTH));

    assign push = inflight && !flush;
    assign pop  = IF_valid && dec_ready;

    // First pair after an odd-word redirect drops the word before the target.
    always_comb begin
        push_pair.instr1 = skip_first ? NOP_INSTR : imem_rdata[63:32];
        push_pair.instr2 = imem_rdata[31:0];
        push_pair.pc     = {{(32 - LS_ADDR_W){1'b0}}, inflight_pc};
    end

    fetch_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_pair),
        .pop       (pop),
        .clear     (flush),
        .count     (count),
        .empty     (empty),
        .head      (head)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // A stop pair halts prefetch once it is buffered; a redirect restarts it.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = RUN;
        end else if ((state == RUN) && push &&
                     (is_stop(push_pair.instr1) || is_stop(push_pair.instr2))) begin
            next_state = STOPPED;
        end
    end

    // Read strobe is forced low while reset is asserted so it drops immediately.
    always_comb begin
        imem_rd_en = rst_n && (state == RUN) && !flush && credit_ok;
    end

    assign imem_addr = fetch_pc[LS_ADDR_W-1:3];

    // Fetch PC, in-flight tracking and the odd-word skip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC[LS_ADDR_W-1:0];
            inflight_pc <= '0;
            inflight    <= 1'b0;
            skip_first  <= 1'b0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                inflight_pc <= fetch_pc;
            end
            if (flush) begin
                fetch_pc   <= {branch_target[LS_ADDR_W-1:3], 3'b000};
                skip_first <= branch_target[2];
            end else begin
                if (imem_rd_en) begin
                    fetch_pc <= fetch_pc + LS_ADDR_W'(8);
                end
                if (push) begin
                    skip_first <= 1'b0;
                end
            end
        end
    end

    // Head outputs read as zero whenever nothing valid is presented.
    assign IF_valid   = !empty;
    assign instr_1    = IF_valid ? head.instr1 : 32'd0;
    assign instr_2    = IF_valid ? head.instr2 : 32'd0;
    assign PC_instr_1 = IF_valid ? head.pc : 32'd0;
    assign PC_instr_2 = IF_valid ? (head.pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with an address-tagged instruction memory.
module tb_instr_fetch;

    logic         clk;
    logic         rst_n;
    logic         imem_rd_en;
    logic [14:0]  imem_addr;
    logic [63:0]  imem_rdata;
    logic [31:0]  instr_1;
    logic [31:0]  instr_2;
    logic [31:0]  PC_instr_1;
    logic [31:0]  PC_instr_2;
    logic         IF_valid;
    logic         dec_ready;
    logic         flush;
    logic [31:0]  branch_target;

    int           total;
    int           bad;
    int           rd_cnt;
    int           unstable;
    logic         stop_en;
    logic [17:0]  stop_addr;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_1       (instr_1),
        .instr_2       (instr_2),
        .PC_instr_1    (PC_instr_1),
        .PC_instr_2    (PC_instr_2),
        .IF_valid      (IF_valid),
        .dec_ready     (dec_ready),
        .flush         (flush),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at a byte address: tagged with the address, or zero (a stop
    // instruction) at the selected stop address.
    function automatic logic [31:0] word(input logic [17:0] a);
        if (stop_en && (a == stop_addr)) begin
            return 32'd0;
        end
        return 32'hA000_0000 | {14'd0, a};
    endfunction

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) begin
            imem_rdata <= {word({imem_addr, 3'b000}), word({imem_addr, 3'b100})};
        end
    end

    // Advance one cycle, drive inputs for it, let outputs settle.
    task automatic applyStimulus(input logic rdy, input logic fl, input logic [31:0] bt);
        @(posedge clk);
        #2;
        dec_ready     = rdy;
        flush         = fl;
        branch_target = bt;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0; rd_cnt = 0; unstable = 0;
        stop_en = 1'b0; stop_addr = '0;
        rst_n = 1'b0; dec_ready = 1'b0; flush = 1'b0; branch_target = '0;
        imem_rdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        checkOutput("rst_valid", 32'(IF_valid), 32'd0);
        checkOutput("rst_rden", 32'(imem_rd_en), 32'd0);
        checkOutput("rst_instr1", instr_1, 32'd0);
        checkOutput("rst_pc1", PC_instr_1, 32'd0);

        // Cycle 0: release reset, first read goes out immediately
        rst_n = 1'b1; dec_ready = 1'b1;
        #1;
        checkOutput("c0_rden", 32'(imem_rd_en), 32'd1);
        checkOutput("c0_addr", 32'(imem_addr), 32'd0);
        checkOutput("c0_valid", 32'(IF_valid), 32'd0);

        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("c1_valid", 32'(IF_valid), 32'd0);
        checkOutput("c1_addr", 32'(imem_addr), 32'd1);

        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("c2_valid", 32'(IF_valid), 32'd1);
        checkOutput("c2_pc1", PC_instr_1, 32'd0);
        checkOutput("c2_pc2", PC_instr_2, 32'd4);
        checkOutput("c2_instr1", instr_1, word(18'h0));
        checkOutput("c2_instr2", instr_2, word(18'h4));

        // Streaming one pair per cycle
        for (int k = 3; k <= 6; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            checkOutput("stream_valid", 32'(IF_valid), 32'd1);
            checkOutput("stream_pc1", PC_instr_1, 32'(8 * (k - 2)));
            checkOutput("stream_instr1", instr_1, word(18'(8 * (k - 2))));
        end
        checkOutput("c6_addr", 32'(imem_addr), 32'd6);

        // Backpressure: one pair stored, one in flight, two more reads fill it
        for (int k = 7; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            if (imem_rd_en) rd_cnt++;
            if (PC_instr_1 !== 32'd40 || instr_1 !== word(18'd40)) unstable++;
        end
        checkOutput("bp_reads", 32'(rd_cnt), 32'd2);
        checkOutput("bp_stable", 32'(unstable), 32'd0);
        checkOutput("bp_full_rden", 32'(imem_rd_en), 32'd0);
        checkOutput("bp_valid", 32'(IF_valid), 32'd1);

        // Drain in order; the read resumes one cycle after the first pop
        for (int k = 17; k <= 22; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            checkOutput("drain_pc1", PC_instr_1, 32'(40 + 8 * (k - 17)));
            checkOutput("drain_instr2", instr_2, word(18'(44 + 8 * (k - 17))));
            if (k == 17) checkOutput("drain_c17_rden", 32'(imem_rd_en), 32'd0);
            if (k == 18) begin
                checkOutput("drain_c18_rden", 32'(imem_rd_en), 32'd1);
                checkOutput("drain_c18_addr", 32'(imem_addr), 32'd9);
            end
        end

        // Flush to an odd word with three pairs stored and a read in flight
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h124);
        checkOutput("fl_rden_n", 32'(imem_rd_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("fl_valid_n1", 32'(IF_valid), 32'd0);
        checkOutput("fl_rden_n1", 32'(imem_rd_en), 32'd1);
        checkOutput("fl_addr_n1", 32'(imem_addr), 32'h24);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("fl_valid_n2", 32'(IF_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("fl_valid_n3", 32'(IF_valid), 32'd1);
        checkOutput("fl_instr1_nop", instr_1, 32'h4020_0000);
        checkOutput("fl_instr2", instr_2, word(18'h124));
        checkOutput("fl_pc1", PC_instr_1, 32'h120);
        checkOutput("fl_pc2", PC_instr_2, 32'h124);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("fl_next_pc1", PC_instr_1, 32'h128);
        checkOutput("fl_next_instr1", instr_1, word(18'h128));
        applyStimulus(1'b1, 1'b0, 32'd0);

        // Stop word at 0x1C; flush issued while credits are available
        stop_en = 1'b1; stop_addr = 18'h1C;
        applyStimulus(1'b1, 1'b1, 32'h10);
        checkOutput("st_flush_rden", 32'(imem_rd_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("st_addr", 32'(imem_addr), 32'h2);
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("st_pc_10", PC_instr_1, 32'h10);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("st_pc_18", PC_instr_1, 32'h18);
        checkOutput("st_stopword", instr_2, 32'd0);
        checkOutput("st_rden", 32'(imem_rd_en), 32'd0);
        rd_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            if (imem_rd_en) rd_cnt++;
        end
        checkOutput("st_no_reads", 32'(rd_cnt), 32'd0);
        checkOutput("st_drained", 32'(IF_valid), 32'd0);

        // Resume with a flush to 0x40
        stop_en = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h40);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("rs_rden", 32'(imem_rd_en), 32'd1);
        checkOutput("rs_addr", 32'(imem_addr), 32'h8);
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("rs_valid", 32'(IF_valid), 32'd1);
        checkOutput("rs_pc1", PC_instr_1, 32'h40);
        checkOutput("rs_instr1", instr_1, word(18'h40));

        // Wrap-around at the top of local store
        applyStimulus(1'b1, 1'b1, 32'h3FFF0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("wr_addr_hi", 32'(imem_addr), 32'h7FFE);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("wr_addr_top", 32'(imem_addr), 32'h7FFF);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("wr_addr_zero", 32'(imem_addr), 32'h0);
        checkOutput("wr_pc_a", PC_instr_1, 32'h3FFF0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("wr_pc_b", PC_instr_1, 32'h3FFF8);
        checkOutput("wr_pc2_b", PC_instr_2, 32'h3FFFC);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("wr_pc_c", PC_instr_1, 32'h0);
        checkOutput("wr_instr_c", instr_1, word(18'h0));

        // Asynchronous reset in the middle of a burst
        applyStimulus(1'b1, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(IF_valid), 32'd0);
        checkOutput("ar_rden", 32'(imem_rd_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ar_restart_rden", 32'(imem_rd_en), 32'd1);
        checkOutput("ar_restart_addr", 32'(imem_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("ar_valid2", 32'(IF_valid), 32'd1);
        checkOutput("ar_pc1", PC_instr_1, 32'd0);
        checkOutput("ar_instr1", instr_1, word(18'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
